countdown_mmss: RTL and testbench

- BCD MM:SS countdown timer. Loads a start value, decrements once per 1 Hz tick, and flags expiry.
- It is the down-counting counterpart of the up-counting mod-60 seconds/minutes chain. It uses the same digit encoding, and its `oc` output signals a borrow where the up chain signals a carry.
- Sits between the tick divider and the display/alarm logic of the clock design.

---
 rtl/countdown_mmss_pkg.sv | 18 +
 rtl/countdown_mmss_digit.sv | 35 +++
 rtl/countdown_mmss.sv | 151 +++++++++++++++
 tb/tb_countdown_mmss.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_mmss_pkg.sv
// rtl/countdown_mmss_pkg.sv - shared types, BCD constants and digit check for the MM:SS countdown
package countdown_mmss_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return d <= BCD_NINE;
    endfunction

endpackage

// File: rtl/countdown_mmss_digit.sv
// rtl/countdown_mmss_digit.sv - one BCD digit counting down with wrap-to-MAX and borrow out
//
// Ports:
//   clk, rst        clock, async active-high reset (q clears to 0)
//   dec_en          decrement this digit this cycle
//   ld_en, ld_val   parallel load (wins over dec_en)
//   q               current digit value
//   borrow          combinational: decrementing through 0, next digit must decrement
module bcd_down_digit
    import countdown_mmss_pkg::*;
#(
    parameter logic [3:0] MAX = BCD_NINE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_en,
    input  logic       ld_en,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       borrow
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (ld_en) begin
            q <= ld_val;
        end else if (dec_en) begin
            q <= (q == 4'd0) ? MAX : q - 4'd1;
        end
    end

    assign borrow = dec_en && (q == 4'd0);

endmodule

// File: rtl/countdown_mmss.sv
// rtl/countdown_mmss.sv - BCD MM:SS countdown timer with load/start/pause control and expiry flags
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   tick                          one-cycle 1 Hz enable
//   load, ld_min_2..ld_sec_1      load request and BCD start value
//   start, pause                  run control
//   min_2, min_1, sec_2, sec_1    current BCD count
//   oc                            pulse: seconds wrapped 00->59 (borrow from minutes)
//   done                          pulse: count reached 00:00
//   expired, running              levels for DONE and RUN
//   err                           pulse: load rejected as non-BCD / out of range
module countdown_mmss
    import countdown_mmss_pkg::*;
#(
    parameter bit          AUTO_RELOAD  = 1'b0,
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] ld_min_2,
    input  logic [3:0] ld_min_1,
    input  logic [3:0] ld_sec_2,
    input  logic [3:0] ld_sec_1,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] min_2,
    output logic [3:0] min_1,
    output logic [3:0] sec_2,
    output logic [3:0] sec_1,
    output logic       oc,
    output logic       done,
    output logic       expired,
    output logic       running,
    output logic       err
);

    localparam logic [3:0] MIN_TENS_LIM = MIN_TENS_MAX[3:0];

    state_t     state, next_state;
    logic [3:0] rl_min_2, rl_min_1, rl_sec_2, rl_sec_1;
    // Set on the expiry edge when auto-reloading; the following cycle restores the start value.
    logic       reload_pend;

    logic       ld_ok, count_zero, count_one, reload_zero;
    logic       do_load, do_reload, do_dec, err_n, done_n;
    logic       dig_ld_en;
    logic [3:0] dv_min_2, dv_min_1, dv_sec_2, dv_sec_1;
    logic       b_sec_1, b_sec_2, b_min_1, b_min_2;

    assign ld_ok = is_bcd_digit(ld_min_2) && is_bcd_digit(ld_min_1) &&
                   is_bcd_digit(ld_sec_2) && is_bcd_digit(ld_sec_1) &&
                   (ld_sec_2 <= BCD_FIVE) && (ld_min_2 <= MIN_TENS_LIM);

    assign count_zero  = {min_2, min_1, sec_2, sec_1} == 16'h0000;
    assign count_one   = {min_2, min_1, sec_2, sec_1} == 16'h0001;
    assign reload_zero = {rl_min_2, rl_min_1, rl_sec_2, rl_sec_1} == 16'h0000;

    // Strict priority chain: load, then start, then pause, then tick.
    always_comb begin
        next_state = state;
        do_load    = 1'b0;
        do_reload  = reload_pend;
        do_dec     = 1'b0;
        err_n      = 1'b0;
        if (load) begin
            if (!ld_ok) begin
                err_n = 1'b1;
            end else if (state != RUN) begin
                do_load    = 1'b1;
                next_state = IDLE;
            end
        end else if (start) begin
            unique case (state)
                IDLE:    if (!count_zero) next_state = RUN;
                PAUSED:  next_state = RUN;
                DONE: begin
                    if (!reload_zero) begin
                        do_reload  = 1'b1;
                        next_state = RUN;
                    end
                end
                default: ;
            endcase
        end else if (pause) begin
            if (state == RUN) next_state = PAUSED;
        end else if (tick && state == RUN && !reload_pend) begin
            do_dec = 1'b1;
            if (count_one && !AUTO_RELOAD) next_state = DONE;
        end
    end

    assign done_n    = do_dec && count_one;
    assign dig_ld_en = do_load || do_reload;
    assign dv_min_2  = do_load ? ld_min_2 : rl_min_2;
    assign dv_min_1  = do_load ? ld_min_1 : rl_min_1;
    assign dv_sec_2  = do_load ? ld_sec_2 : rl_sec_2;
    assign dv_sec_1  = do_load ? ld_sec_1 : rl_sec_1;

    bcd_down_digit #(.MAX(BCD_NINE)) u_sec_1 (
        .clk(clk), .rst(rst), .dec_en(do_dec), .ld_en(dig_ld_en),
        .ld_val(dv_sec_1), .q(sec_1), .borrow(b_sec_1)
    );
    bcd_down_digit #(.MAX(BCD_FIVE)) u_sec_2 (
        .clk(clk), .rst(rst), .dec_en(b_sec_1), .ld_en(dig_ld_en),
        .ld_val(dv_sec_2), .q(sec_2), .borrow(b_sec_2)
    );
    bcd_down_digit #(.MAX(BCD_NINE)) u_min_1 (
        .clk(clk), .rst(rst), .dec_en(b_sec_2), .ld_en(dig_ld_en),
        .ld_val(dv_min_1), .q(min_1), .borrow(b_min_1)
    );
    bcd_down_digit #(.MAX(MIN_TENS_LIM)) u_min_2 (
        .clk(clk), .rst(rst), .dec_en(b_min_1), .ld_en(dig_ld_en),
        .ld_val(dv_min_2), .q(min_2), .borrow(b_min_2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rl_min_2    <= 4'd0;
            rl_min_1    <= 4'd0;
            rl_sec_2    <= 4'd0;
            rl_sec_1    <= 4'd0;
            reload_pend <= 1'b0;
            oc          <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            expired     <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= next_state;
            if (do_load) begin
                rl_min_2 <= ld_min_2;
                rl_min_1 <= ld_min_1;
                rl_sec_2 <= ld_sec_2;
                rl_sec_1 <= ld_sec_1;
            end
            reload_pend <= done_n && AUTO_RELOAD;
            oc          <= b_sec_2;
            done        <= done_n;
            // A minutes-tens borrow cannot happen because 00:00 stops the count first;
            // if it ever did, it is surfaced on err instead of silently wrapping.
            err         <= err_n || b_min_2;
            expired     <= next_state == DONE;
            running     <= next_state == RUN;
        end
    end

endmodule

// File: tb/tb_countdown_mmss.sv
// tb/tb_countdown_mmss.sv - randomized and directed checks of countdown_mmss against a seconds-based model
module tb_countdown_mmss;

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
    localparam int MT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [3:0] ld_min_2 = 4'd0, ld_min_1 = 4'd0, ld_sec_2 = 4'd0, ld_sec_1 = 4'd0;

    logic [3:0] min_2 [2];
    logic [3:0] min_1 [2];
    logic [3:0] sec_2 [2];
    logic [3:0] sec_1 [2];
    logic       oc [2], done [2], expired [2], running [2], err [2];

    int n_vec = 0;
    int n_err = 0;

    // Model: count held as total seconds; instance 0 one-shot, instance 1 auto-reload.
    int m_secs [2];
    int m_rl   [2];
    int m_st   [2];
    bit m_pend [2];
    bit e_oc   [2];
    bit e_done [2];
    bit e_err  [2];

    always #5 clk = ~clk;

    countdown_mmss #(.AUTO_RELOAD(1'b0), .MIN_TENS_MAX(MT)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .ld_min_2(ld_min_2), .ld_min_1(ld_min_1), .ld_sec_2(ld_sec_2), .ld_sec_1(ld_sec_1),
        .start(start), .pause(pause),
        .min_2(min_2[0]), .min_1(min_1[0]), .sec_2(sec_2[0]), .sec_1(sec_1[0]),
        .oc(oc[0]), .done(done[0]), .expired(expired[0]), .running(running[0]), .err(err[0])
    );

    countdown_mmss #(.AUTO_RELOAD(1'b1), .MIN_TENS_MAX(MT)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .ld_min_2(ld_min_2), .ld_min_1(ld_min_1), .ld_sec_2(ld_sec_2), .ld_sec_1(ld_sec_1),
        .start(start), .pause(pause),
        .min_2(min_2[1]), .min_1(min_1[1]), .sec_2(sec_2[1]), .sec_1(sec_1[1]),
        .oc(oc[1]), .done(done[1]), .expired(expired[1]), .running(running[1]), .err(err[1])
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, sc;
        m  = s / 60;
        sc = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [15:0] dut_digits(input int k);
        return {min_2[k], min_1[k], sec_2[k], sec_1[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_secs[k] = 0; m_rl[k] = 0; m_st[k] = S_IDLE; m_pend[k] = 0;
            e_oc[k] = 0; e_done[k] = 0; e_err[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit tk, input bit ld, input bit st,
                              input bit ps, input logic [15:0] ldd);
        bit was_pend;
        int d3, d2, d1, d0;
        was_pend = m_pend[k];
        d3 = int'(ldd[15:12]); d2 = int'(ldd[11:8]); d1 = int'(ldd[7:4]); d0 = int'(ldd[3:0]);
        e_oc[k] = 0; e_done[k] = 0; e_err[k] = 0;
        if (was_pend) begin
            m_secs[k] = m_rl[k];
            m_pend[k] = 0;
        end
        if (ld) begin
            if (d3 > MT || d2 > 9 || d1 > 5 || d0 > 9) begin
                e_err[k] = 1;
            end else if (m_st[k] != S_RUN) begin
                m_secs[k] = (d3 * 10 + d2) * 60 + d1 * 10 + d0;
                m_rl[k]   = m_secs[k];
                m_st[k]   = S_IDLE;
            end
        end else if (st) begin
            if (m_st[k] == S_IDLE && m_secs[k] != 0) m_st[k] = S_RUN;
            else if (m_st[k] == S_PAUSED) m_st[k] = S_RUN;
            else if (m_st[k] == S_DONE && m_rl[k] != 0) begin
                m_secs[k] = m_rl[k];
                m_st[k]   = S_RUN;
            end
        end else if (ps) begin
            if (m_st[k] == S_RUN) m_st[k] = S_PAUSED;
        end else if (tk && m_st[k] == S_RUN && !was_pend) begin
            if (m_secs[k] % 60 == 0) e_oc[k] = 1;
            m_secs[k] = m_secs[k] - 1;
            if (m_secs[k] == 0) begin
                e_done[k] = 1;
                if (k == 1) m_pend[k] = 1;
                else        m_st[k] = S_DONE;
            end
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_u%0d_digits", ph, k), dut_digits(k), to_bcd(m_secs[k]));
            check($sformatf("%s_u%0d_oc", ph, k), 16'(oc[k]), 16'(e_oc[k]));
            check($sformatf("%s_u%0d_done", ph, k), 16'(done[k]), 16'(e_done[k]));
            check($sformatf("%s_u%0d_err", ph, k), 16'(err[k]), 16'(e_err[k]));
            check($sformatf("%s_u%0d_expired", ph, k), 16'(expired[k]), 16'(m_st[k] == S_DONE));
            check($sformatf("%s_u%0d_running", ph, k), 16'(running[k]), 16'(m_st[k] == S_RUN));
        end
    endtask

    task automatic do_cyc(input string ph, input bit tk, input bit ld, input bit st,
                          input bit ps, input logic [15:0] ldd);
        tick = tk; load = ld; start = st; pause = ps;
        {ld_min_2, ld_min_1, ld_sec_2, ld_sec_1} = ldd;
        model_step(0, tk, ld, st, ps, ldd);
        model_step(1, tk, ld, st, ps, ldd);
        @(posedge clk);
        #1;
        check_all(ph);
        tick = 0; load = 0; start = 0; pause = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // 01:00 -> 00:59 with a borrow pulse
        do_cyc("l0100", 0, 1, 0, 0, 16'h0100);
        do_cyc("s0100", 0, 0, 1, 0, 16'h0);
        do_cyc("t0100", 1, 0, 0, 0, 16'h0);
        check("borrow_digits", dut_digits(0), 16'h0059);
        check("borrow_oc", 16'(oc[0]), 16'h1);
        do_cyc("idle0100", 0, 0, 0, 0, 16'h0);
        check("borrow_oc_once", 16'(oc[0]), 16'h0);

        // 00:02 -> expiry, then a tick in DONE is ignored
        do_cyc("p1", 0, 0, 0, 1, 16'h0);
        do_cyc("l0002", 0, 1, 0, 0, 16'h0002);
        do_cyc("s0002", 0, 0, 1, 0, 16'h0);
        do_cyc("t1_0002", 1, 0, 0, 0, 16'h0);
        check("exp_step1", dut_digits(0), 16'h0001);
        do_cyc("t2_0002", 1, 0, 0, 0, 16'h0);
        check("exp_done", 16'(done[0]), 16'h1);
        check("exp_expired", 16'(expired[0]), 16'h1);
        do_cyc("t3_0002", 1, 0, 0, 0, 16'h0);
        check("exp_hold", dut_digits(0), 16'h0000);
        check("exp_no_redone", 16'(done[0]), 16'h0);

        // pause holds, coincident tick dropped, resume
        do_cyc("p2", 0, 0, 0, 1, 16'h0);
        do_cyc("l0005", 0, 1, 0, 0, 16'h0005);
        do_cyc("s0005", 0, 0, 1, 0, 16'h0);
        do_cyc("t0005", 1, 0, 0, 0, 16'h0);
        do_cyc("pt0005", 1, 0, 0, 1, 16'h0);
        check("pause_drop", dut_digits(0), 16'h0004);
        for (int i = 0; i < 3; i++) do_cyc("tp0005", 1, 0, 0, 0, 16'h0);
        check("pause_hold", dut_digits(0), 16'h0004);
        do_cyc("r0005", 0, 0, 1, 0, 16'h0);
        do_cyc("tr0005", 1, 0, 0, 0, 16'h0);
        check("resume", dut_digits(0), 16'h0003);

        // load validation
        do_cyc("p3", 0, 0, 0, 1, 16'h0);
        do_cyc("lbad_sec", 0, 1, 0, 0, 16'h0660);
        check("bad_sec_err", 16'(err[0]), 16'h1);
        check("bad_sec_keep", dut_digits(0), 16'h0003);
        do_cyc("lbad_min", 0, 1, 0, 0, 16'h6000);
        do_cyc("l1000", 0, 1, 0, 0, 16'h1000);
        check("ok_1000", dut_digits(0), 16'h1000);
        do_cyc("s1000", 0, 0, 1, 0, 16'h0);
        do_cyc("lrun", 0, 1, 0, 0, 16'h0030);
        check("run_load_ignored", dut_digits(0), 16'h1000);
        check("run_load_no_err", 16'(err[0]), 16'h0);

        // auto-reload instance
        do_cyc("p4", 0, 0, 0, 1, 16'h0);
        do_cyc("l0001", 0, 1, 0, 0, 16'h0001);
        do_cyc("s0001", 0, 0, 1, 0, 16'h0);
        do_cyc("t1_0001", 1, 0, 0, 0, 16'h0);
        check("ar_done", 16'(done[1]), 16'h1);
        check("ar_zero", dut_digits(1), 16'h0000);
        do_cyc("i_0001", 0, 0, 0, 0, 16'h0);
        check("ar_reload", dut_digits(1), 16'h0001);
        check("ar_running", 16'(running[1]), 16'h1);
        check("ar_not_expired", 16'(expired[1]), 16'h0);
        do_cyc("t2_0001", 1, 0, 0, 0, 16'h0);
        check("ar_done2", 16'(done[1]), 16'h1);
        check("ar_zero2", dut_digits(1), 16'h0000);
        do_cyc("i2_0001", 0, 0, 0, 0, 16'h0);

        // asynchronous reset mid-count
        do_cyc("p5", 0, 0, 0, 1, 16'h0);
        do_cyc("l1234", 0, 1, 0, 0, 16'h1234);
        do_cyc("s1234", 0, 0, 1, 0, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("arst_u%0d_digits", k), dut_digits(k), 16'h0000);
            check($sformatf("arst_u%0d_flags", k),
                  16'({oc[k], done[k], err[k], expired[k], running[k]}), 16'h0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic; ticks never coincide with other controls
        for (int n = 0; n < 2000; n++) begin
            int r;
            logic [15:0] ldd;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                ldd[15:12] = 4'($urandom_range(0, 6));
                ldd[11:8]  = 4'($urandom_range(0, 10));
                ldd[7:4]   = 4'($urandom_range(0, 6));
                ldd[3:0]   = 4'($urandom_range(0, 10));
                if ($urandom_range(0, 3) != 0) ldd[15:8] = 8'h00;
                if ($urandom_range(0, 1) != 0) ldd[7:4] = 4'h0;
                do_cyc("rnd_load", 0, 1, 0, 0, ldd);
            end else if (r < 11) begin
                do_cyc("rnd_start", 0, 0, 1, 0, 16'h0);
            end else if (r < 14) begin
                do_cyc("rnd_pause", 0, 0, 0, 1, 16'h0);
            end else if (r < 60) begin
                do_cyc("rnd_tick", 1, 0, 0, 0, 16'h0);
            end else begin
                do_cyc("rnd_idle", 0, 0, 0, 0, 16'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
